exc_sequencer: RTL

Multi-cycle exception sequencer for the MIPS pipeline. It takes the exception flags raised by the retiring instruction (overflow, break, divide-by-zero) plus the single-step request, and picks one by fixed priority. It then walks the pipeline through flush, cause/EPC save, vector to handler, handler residency and return on eret. It sits beside the writeback stage and drives the PC-select mux, the pipeline flush/stall lines and the cause/EPC registers.

---
 rtl/exc_pkg.sv | 27 ++
 rtl/exc_sequencer_if.sv | 40 ++++
 rtl/exc_prio_enc.sv | 30 +++
 rtl/exc_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: definitions shared by the exception sequencer slice.
//   - cause_e : cause codes written to the cause register
//   - state_e : sequencer FSM states
//   - DEFAULT_HANDLER_ADDR / DEFAULT_STEP_LIMIT : parameter defaults
package exc_pkg;

    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_OVF  = 3'd1,
        CAUSE_BRK  = 3'd2,
        CAUSE_DIV  = 3'd3,
        CAUSE_STEP = 3'd4
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_SAVE    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_HANDLER = 3'd4,
        ST_RETURN  = 3'd5
    } state_e;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0180;
    localparam logic [31:0] DEFAULT_STEP_LIMIT   = 32'd400;

endpackage

// File: rtl/exc_sequencer_if.sv
// exc_sequencer_if: connection between the writeback stage / PC mux and the
// exception sequencer.
//   pipeline -> sequencer : valid_wb, inst_pc, exc_ovf, exc_brk, exc_div,
//                           step_en, eret
//   sequencer -> pipeline : flush, stall, pc_load, pc_target, cause_we,
//                           cause, epc, in_handler, step_hit
// master = pipeline side, slave = sequencer side.
interface exc_sequencer_if;

    logic        valid_wb;
    logic [31:0] inst_pc;
    logic        exc_ovf;
    logic        exc_brk;
    logic        exc_div;
    logic        step_en;
    logic        eret;

    logic        flush;
    logic        stall;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        cause_we;
    logic [2:0]  cause;
    logic [31:0] epc;
    logic        in_handler;
    logic        step_hit;

    modport master (
        output valid_wb, inst_pc, exc_ovf, exc_brk, exc_div, step_en, eret,
        input  flush, stall, pc_load, pc_target, cause_we, cause, epc,
               in_handler, step_hit
    );

    modport slave (
        input  valid_wb, inst_pc, exc_ovf, exc_brk, exc_div, step_en, eret,
        output flush, stall, pc_load, pc_target, cause_we, cause, epc,
               in_handler, step_hit
    );

endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority encoder for the retiring instruction's
// exception sources. Priority: div > ovf > brk > step.
//   div, ovf, brk : exception flags (already qualified by the caller)
//   step_ok       : single-step trap is eligible
//   hit           : at least one source active
//   cause         : code of the winning source (CAUSE_NONE when !hit)
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic   div,
    input  logic   ovf,
    input  logic   brk,
    input  logic   step_ok,
    output logic   hit,
    output cause_e cause
);

    always_comb begin
        // NOTE: outputs are given a default before the priority chain so no
        // path through the block can leave them unassigned (no latch).
        hit   = 1'b1;
        cause = CAUSE_NONE;
        if (div)          cause = CAUSE_DIV;
        else if (ovf)     cause = CAUSE_OVF;
        else if (brk)     cause = CAUSE_BRK;
        else if (step_ok) cause = CAUSE_STEP;
        else              hit   = 1'b0;
    end

endmodule

// File: rtl/exc_sequencer.sv
// exc_sequencer: multi-cycle exception sequencer beside the writeback stage.
// Accepts one exception (or single-step trap) per retire while idle, then
// walks IDLE -> FLUSH -> SAVE -> VECTOR -> HANDLER -> RETURN -> IDLE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : exc_sequencer_if.slave (retire info in; flush/stall,
//                PC redirect, cause/EPC write and status out)
// All control outputs decode from the state register and the captured
// cause/epc registers only, so exception flags never reach flush/pc_load
// combinationally.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter logic [31:0] STEP_LIMIT   = DEFAULT_STEP_LIMIT
)(
    input  logic            clk,
    input  logic            rst_n,
    exc_sequencer_if.slave  bus
);

    state_e      state, next_state;
    cause_e      cause_q;
    logic [31:0] epc_q;

    logic [31:0] ret_pc;
    logic        step_ok;
    logic        exc_hit;
    cause_e      exc_cause;
    logic        accept;

    logic        flush, stall, pc_load, cause_we, in_handler;
    logic [31:0] pc_target;

    // Return address wraps at 32 bits; the step window uses the same value.
    assign ret_pc  = bus.inst_pc + 32'd4;
    assign step_ok = bus.step_en && (ret_pc < STEP_LIMIT);

    exc_prio_enc u_prio (
        .div     (bus.exc_div),
        .ovf     (bus.exc_ovf),
        .brk     (bus.exc_brk),
        .step_ok (step_ok),
        .hit     (exc_hit),
        .cause   (exc_cause)
    );

    // Flags are only looked at while idle, which masks nesting in HANDLER
    // and drops anything raised during RETURN.
    assign accept = (state == ST_IDLE) && bus.valid_wb && exc_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // updates from pre-edge values regardless of statement order.
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // cause/epc hold from capture until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= CAUSE_NONE;
            epc_q   <= 32'd0;
        end else if (accept) begin
            cause_q <= exc_cause;
            epc_q   <= ret_pc;
        end
    end

    always_comb begin
        next_state = state;
        flush      = 1'b0;
        stall      = 1'b0;
        pc_load    = 1'b0;
        pc_target  = 32'd0;
        cause_we   = 1'b0;
        in_handler = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush      = 1'b1;
                stall      = 1'b1;
                next_state = ST_SAVE;
            end
            ST_SAVE: begin
                cause_we   = 1'b1;
                stall      = 1'b1;
                next_state = ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_load    = 1'b1;
                pc_target  = HANDLER_ADDR;
                in_handler = 1'b1;
                next_state = ST_HANDLER;
            end
            ST_HANDLER: begin
                in_handler = 1'b1;
                if (bus.eret) next_state = ST_RETURN;
            end
            ST_RETURN: begin
                pc_load    = 1'b1;
                pc_target  = epc_q;
                flush      = 1'b1;
                in_handler = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bus.flush      = flush;
    assign bus.stall      = stall;
    assign bus.pc_load    = pc_load;
    assign bus.pc_target  = pc_target;
    assign bus.cause_we   = cause_we;
    assign bus.in_handler = in_handler;
    assign bus.cause      = cause_q;
    assign bus.epc        = epc_q;
    // Single-cycle pulse in the first cycle after a step trap is taken,
    // the cycle in which the captured cause/epc first appear.
    assign bus.step_hit   = (state == ST_FLUSH) && (cause_q == CAUSE_STEP);

endmodule
